// File: rtl/driver_remap.sv
// driver_remap: per-group LED channel remapper for LED driver frames.
// Each driver word holds NB_BITS bit-planes of NB_LEDS RGB triplets. The
// red/green pair and the blue bit of every LED output slot are fetched from
// a source LED selected by a per-group table.
// Optional feature macro: DRIVER_REMAP_LUT_WRITE_EN
//   defined   -> host-writable shadow tables, copied to the active tables
//                on lut_commit
//   undefined -> tables are fixed identity constants; lut_* inputs unused
module driver_remap #(
    parameter int NB_DRIVERS = 15,
    parameter int NB_GROUPS  = 3,
    parameter int NB_LEDS    = 16,
    parameter int NB_BITS    = 9
) (
    input  logic                                        clk,
    input  logic                                        nrst,
    input  logic [NB_DRIVERS*3*NB_LEDS*NB_BITS-1:0]     data_in,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [NB_DRIVERS*3*NB_LEDS*NB_BITS-1:0]     data_out,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    input  logic                                        bypass,
    input  logic                                        lut_we,
    input  logic [((NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1)-1:0] lut_group,
    input  logic                                        lut_sel,
    input  logic [((NB_LEDS > 1) ? $clog2(NB_LEDS) : 1)-1:0]     lut_led,
    input  logic [((NB_LEDS > 1) ? $clog2(NB_LEDS) : 1)-1:0]     lut_val,
    input  logic                                        lut_commit
);

    localparam int W   = 3 * NB_LEDS * NB_BITS;     // bits per driver word
    localparam int DW  = NB_DRIVERS * W;            // bits per frame
    localparam int PL  = 3 * NB_LEDS;               // bits per bit-plane
    localparam int DPG = NB_DRIVERS / NB_GROUPS;    // drivers per group
    localparam int GW  = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1;
    localparam int LW  = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;

    // Active tables as seen by the datapath: source LED per output LED.
    logic [LW-1:0] w_rg [NB_GROUPS][NB_LEDS];
    logic [LW-1:0] w_b  [NB_GROUPS][NB_LEDS];

    logic          w_accept;
    logic [DW-1:0] w_map;
    logic          r_out_valid;
    logic [DW-1:0] r_data;

`ifdef DRIVER_REMAP_LUT_WRITE_EN
    // Values outside the LED range are dropped; out-of-range group or LED
    // indices simply match no table entry below.
    logic w_wr_ok;
    assign w_wr_ok = lut_we && (int'(lut_val) < NB_LEDS);

    for (genvar g = 0; g < NB_GROUPS; g++) begin : g_grp
        for (genvar l = 0; l < NB_LEDS; l++) begin : g_ent
            logic [LW-1:0] r_sh_rg;
            logic [LW-1:0] r_sh_b;
            logic [LW-1:0] r_act_rg;
            logic [LW-1:0] r_act_b;
            logic          w_hit_rg;
            logic          w_hit_b;

            assign w_hit_rg = w_wr_ok && !lut_sel && (lut_group == GW'(g)) && (lut_led == LW'(l));
            assign w_hit_b  = w_wr_ok &&  lut_sel && (lut_group == GW'(g)) && (lut_led == LW'(l));

            // Shadow entry takes host writes; active entry reloads from shadow on commit,
            // forwarding a write that lands in the commit cycle itself.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    r_sh_rg  <= LW'(l);
                    r_sh_b   <= LW'(l);
                    r_act_rg <= LW'(l);
                    r_act_b  <= LW'(l);
                end else begin
                    if (w_hit_rg) begin
                        r_sh_rg <= lut_val;
                    end else begin
                        r_sh_rg <= r_sh_rg;
                    end
                    if (w_hit_b) begin
                        r_sh_b <= lut_val;
                    end else begin
                        r_sh_b <= r_sh_b;
                    end
                    if (lut_commit) begin
                        r_act_rg <= w_hit_rg ? lut_val : r_sh_rg;
                        r_act_b  <= w_hit_b  ? lut_val : r_sh_b;
                    end else begin
                        r_act_rg <= r_act_rg;
                        r_act_b  <= r_act_b;
                    end
                end
            end

            assign w_rg[g][l] = r_act_rg;
            assign w_b[g][l]  = r_act_b;
        end
    end
`else
    // Fixed identity tables; the table-write interface has no effect.
    logic w_unused_lut;
    assign w_unused_lut = ^{lut_we, lut_group, lut_sel, lut_led, lut_val, lut_commit};

    for (genvar g = 0; g < NB_GROUPS; g++) begin : g_grp
        for (genvar l = 0; l < NB_LEDS; l++) begin : g_ent
            assign w_rg[g][l] = LW'(l);
            assign w_b[g][l]  = LW'(l);
        end
    end
`endif

    // Remap network: per plane, split into colour vectors and pick the source LED.
    for (genvar d = 0; d < NB_DRIVERS; d++) begin : g_drv
        for (genvar b = 0; b < NB_BITS; b++) begin : g_pln
            localparam int BASE = d * W + b * PL;
            localparam int GRP  = d / DPG;
            logic [NB_LEDS-1:0] w_c0;
            logic [NB_LEDS-1:0] w_c1;
            logic [NB_LEDS-1:0] w_c2;
            for (genvar l = 0; l < NB_LEDS; l++) begin : g_led
                assign w_c0[l] = data_in[BASE + 3*l + 0];
                assign w_c1[l] = data_in[BASE + 3*l + 1];
                assign w_c2[l] = data_in[BASE + 3*l + 2];
                assign w_map[BASE + 3*l + 0] = w_c0[w_rg[GRP][l]];
                assign w_map[BASE + 3*l + 1] = w_c1[w_rg[GRP][l]];
                assign w_map[BASE + 3*l + 2] = w_c2[w_b[GRP][l]];
            end
        end
    end

    // Single-entry output stage: the slot is free when empty or being drained.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Output register: load on accept, drop valid on consume, otherwise hold.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_out_valid <= 1'b0;
            r_data      <= {DW{1'b0}};
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_data      <= bypass ? data_in : w_map;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_driver_remap.sv
// Directed testbench for driver_remap. Expectations follow the build: when
// DRIVER_REMAP_LUT_WRITE_EN is undefined, table writes must have no effect.
module tb_driver_remap;

    localparam int NB_DRIVERS = 15;
    localparam int NB_GROUPS  = 3;
    localparam int NB_LEDS    = 16;
    localparam int NB_BITS    = 9;
    localparam int W   = 3 * NB_LEDS * NB_BITS;
    localparam int DW  = NB_DRIVERS * W;
    localparam int PL  = 3 * NB_LEDS;
    localparam int DPG = NB_DRIVERS / NB_GROUPS;
`ifdef DRIVER_REMAP_LUT_WRITE_EN
    localparam bit LUT_EN = 1'b1;
`else
    localparam bit LUT_EN = 1'b0;
`endif

    logic          clk;
    logic          nrst;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic          bypass;
    logic          lut_we;
    logic [1:0]    lut_group;
    logic          lut_sel;
    logic [3:0]    lut_led;
    logic [3:0]    lut_val;
    logic          lut_commit;

    int errors = 0;
    int checks = 0;

    // Reference tables (shadow and active) kept by the bench.
    int m_sh_rg [NB_GROUPS][NB_LEDS];
    int m_sh_b  [NB_GROUPS][NB_LEDS];
    int m_rg    [NB_GROUPS][NB_LEDS];
    int m_b     [NB_GROUPS][NB_LEDS];

    driver_remap #(
        .NB_DRIVERS(NB_DRIVERS), .NB_GROUPS(NB_GROUPS),
        .NB_LEDS(NB_LEDS), .NB_BITS(NB_BITS)
    ) dut (
        .clk(clk), .nrst(nrst),
        .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .bypass(bypass), .lut_we(lut_we), .lut_group(lut_group),
        .lut_sel(lut_sel), .lut_led(lut_led), .lut_val(lut_val),
        .lut_commit(lut_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_frame();
        logic [DW-1:0] f;
        for (int i = 0; i < DW; i++) f[i] = 1'($urandom_range(1, 0));
        return f;
    endfunction

    function automatic int firstdiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < DW; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] f, input logic byp);
        logic [DW-1:0] o;
        int base;
        int g;
        if (byp) return f;
        o = '0;
        for (int d = 0; d < NB_DRIVERS; d++) begin
            g = d / DPG;
            for (int b = 0; b < NB_BITS; b++) begin
                base = d * W + b * PL;
                for (int l = 0; l < NB_LEDS; l++) begin
                    o[base + 3*l + 0] = f[base + 3*m_rg[g][l] + 0];
                    o[base + 3*l + 1] = f[base + 3*m_rg[g][l] + 1];
                    o[base + 3*l + 2] = f[base + 3*m_b[g][l]  + 2];
                end
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NB_GROUPS; g++)
            for (int l = 0; l < NB_LEDS; l++) begin
                m_sh_rg[g][l] = l; m_sh_b[g][l] = l; m_rg[g][l] = l; m_b[g][l] = l;
            end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; data_in = '0; bypass = 1'b0; out_ready = 1'b1;
        lut_we = 1'b0; lut_group = 2'd0; lut_sel = 1'b0; lut_led = 4'd0;
        lut_val = 4'd0; lut_commit = 1'b0;
    endtask

    // All driving tasks start at a falling edge and end at the next one.
    task automatic lut_write(input int g, input bit sel, input int led, input int val);
        lut_we = 1'b1; lut_group = 2'(g); lut_sel = sel; lut_led = 4'(led); lut_val = 4'(val);
        @(negedge clk);
        lut_we = 1'b0;
        if (LUT_EN && g < NB_GROUPS && led < NB_LEDS && val < NB_LEDS) begin
            if (sel) m_sh_b[g][led] = val; else m_sh_rg[g][led] = val;
        end
    endtask

    task automatic lut_commit_pulse();
        lut_commit = 1'b1;
        @(negedge clk);
        lut_commit = 1'b0;
        if (LUT_EN) begin
            m_rg = m_sh_rg; m_b = m_sh_b;
        end
    endtask

    task automatic send_one(input logic [DW-1:0] f, input logic byp,
                            output logic [DW-1:0] got, output logic gv);
        in_valid = 1'b1; data_in = f; bypass = byp;
        @(negedge clk);
        got = data_out; gv = out_valid;
        in_valid = 1'b0; bypass = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data_out first nonzero bit=%0d", firstdiff(data_out, '0)); end
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_identity();
        logic [DW-1:0] f;
        logic [DW-1:0] got;
        logic gv;
        f = rand_frame();
        send_one(f, 1'b0, got, gv);
        checks++;
        if (gv !== 1'b1) begin errors++; $display("FAIL identity_valid got=%b want=1", gv); end
        checks++;
        if (got !== f) begin errors++; $display("FAIL identity_data differs at bit %0d", firstdiff(got, f)); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL valid_clear got=%b want=0", out_valid); end
        f = rand_frame();
        send_one(f, 1'b1, got, gv);
        checks++;
        if (got !== f || gv !== 1'b1) begin errors++; $display("FAIL bypass_identity valid=%b diff bit %0d", gv, firstdiff(got, f)); end
        @(negedge clk);
    endtask

    task automatic test_remap();
        logic [DW-1:0] f;
        logic [DW-1:0] e;
        logic [DW-1:0] got;
        logic gv;
        lut_write(0, 1'b0, 0, 6);
        lut_write(0, 1'b1, 0, 8);
        lut_commit_pulse();
        f = '0; f[18] = 1'b1; f[19] = 1'b1; f[26] = 1'b1;
        e = f;
        if (LUT_EN) begin e[0] = 1'b1; e[1] = 1'b1; e[2] = 1'b1; end
        send_one(f, 1'b0, got, gv);
        checks++;
        if (got !== e || gv !== 1'b1) begin errors++; $display("FAIL remap_led0 valid=%b diff bit %0d", gv, firstdiff(got, e)); end
        f = rand_frame();
        send_one(f, 1'b0, got, gv);
        checks++;
        if (got[DW-1:5*W] !== f[DW-1:5*W]) begin errors++; $display("FAIL remap_other_groups differs at bit %0d", firstdiff(got, f)); end
        checks++;
        if (got !== model(f, 1'b0)) begin errors++; $display("FAIL remap_full differs at bit %0d", firstdiff(got, model(f, 1'b0))); end
        send_one(f, 1'b1, got, gv);
        checks++;
        if (got !== f) begin errors++; $display("FAIL remap_bypass differs at bit %0d", firstdiff(got, f)); end
        @(negedge clk);
    endtask

    task automatic test_commit_same_cycle();
        logic [DW-1:0] f;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [DW-1:0] got1;
        logic [DW-1:0] got2;
        lut_write(1, 1'b0, 0, 2);
        f = '0; f[5*W + 6] = 1'b1;
        e1 = f;
        e2 = f;
        if (LUT_EN) e2[5*W + 0] = 1'b1;
        in_valid = 1'b1; data_in = f; lut_commit = 1'b1;
        @(negedge clk);
        lut_commit = 1'b0;
        if (LUT_EN) begin m_rg = m_sh_rg; m_b = m_sh_b; end
        got1 = data_out;
        @(negedge clk);
        got2 = data_out;
        in_valid = 1'b0;
        checks++;
        if (got1 !== e1) begin errors++; $display("FAIL commit_cycle_frame differs at bit %0d", firstdiff(got1, e1)); end
        checks++;
        if (got2 !== e2) begin errors++; $display("FAIL post_commit_frame differs at bit %0d", firstdiff(got2, e2)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] f;
        logic [DW-1:0] got;
        logic gv;
        out_ready = 1'b0; in_valid = 1'b1; data_in = rand_frame();
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL held_before_reset got=%b want=1", out_valid); end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0) begin errors++; $display("FAIL async_reset valid=%b first nonzero bit=%0d", out_valid, firstdiff(data_out, '0)); end
        @(negedge clk);
        nrst = 1'b1; out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        f = '0; f[18] = 1'b1; f[19] = 1'b1; f[26] = 1'b1; f[5*W + 6] = 1'b1;
        send_one(f, 1'b0, got, gv);
        checks++;
        if (got !== f) begin errors++; $display("FAIL tables_identity_after_reset differs at bit %0d", firstdiff(got, f)); end
        @(negedge clk);
    endtask

    task automatic test_invalid_write();
        logic [DW-1:0] f;
        logic [DW-1:0] got;
        logic gv;
        lut_write(3, 1'b0, 0, 5);
        lut_write(3, 1'b1, 4, 9);
        lut_commit_pulse();
        f = rand_frame();
        send_one(f, 1'b0, got, gv);
        checks++;
        if (got !== f) begin errors++; $display("FAIL bad_group_write differs at bit %0d", firstdiff(got, f)); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] fa;
        logic [DW-1:0] fb;
        logic [DW-1:0] cur;
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] ev;
        logic cur_byp;
        logic ov;
        int sent;
        int recv;
        int cyc;
        fa = rand_frame(); fb = rand_frame();
        in_valid = 1'b1; data_in = fa; out_ready = 1'b1;
        @(negedge clk);
        data_in = fb; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== fa) begin
                errors++;
                $display("FAIL stall_hold cycle %0d in_ready=%b valid=%b diff bit %0d", i, in_ready, out_valid, firstdiff(data_out, fa));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || data_out !== fb) begin errors++; $display("FAIL stall_release valid=%b diff bit %0d", out_valid, firstdiff(data_out, fb)); end
        @(negedge clk);
        sent = 0; recv = 0; cyc = 0;
        cur = rand_frame(); cur_byp = 1'($urandom_range(1, 0));
        while (recv < 100 && cyc < 2000) begin
            ov = out_valid;
            out_ready = ($urandom_range(3, 0) != 0);
            in_valid = (sent < 100);
            data_in = cur; bypass = cur_byp;
            if (ov && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_frame at output %0d", recv);
                end else begin
                    ev = exp_q.pop_front();
                    if (data_out !== ev) begin errors++; $display("FAIL stream_frame %0d differs at bit %0d", recv, firstdiff(data_out, ev)); end
                end
                recv++;
            end
            if (in_valid && (!ov || out_ready)) begin
                exp_q.push_back(model(cur, cur_byp));
                sent++;
                cur = rand_frame(); cur_byp = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; bypass = 1'b0; out_ready = 1'b1;
        checks++;
        if (recv != 100 || exp_q.size() != 0) begin errors++; $display("FAIL stream_count received=%0d want=100 pending=%0d", recv, exp_q.size()); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_remap();
        test_commit_same_cycle();
        test_reset_mid();
        test_invalid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/driver_remap.md
DRIVER_REMAP -- requirements
Module: driver_remap

Interface
REQ-001 SHALL have parameter NB_DRIVERS, default 15, number of LED driver channels.
REQ-002 SHALL have parameter NB_GROUPS, default 3, number of remap groups; NB_DRIVERS divisible by NB_GROUPS.
REQ-003 SHALL have parameter NB_LEDS, default 16, LEDs per driver.
REQ-004 SHALL have parameter NB_BITS, default 9, bit-planes per driver word; W = 48*NB_BITS/16*NB_LEDS/... defined as W = 3*NB_LEDS*NB_BITS.
REQ-005 SHALL have ports: clk  in  1  system clock; nrst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: data_in  in  NB_DRIVERS x W  input frame; in_valid  in  1; in_ready  out  1.
REQ-007 SHALL have ports: data_out  out  NB_DRIVERS x W  remapped frame; out_valid  out  1; out_ready  in  1.
REQ-008 SHALL have ports: bypass  in  1  sampled with each accepted frame, 1 = copy unmapped.
REQ-009 SHALL have ports: lut_we  in  1; lut_group  in  clog2(NB_GROUPS); lut_sel  in  1 (0 = red/green, 1 = blue); lut_led  in  clog2(NB_LEDS); lut_val  in  clog2(NB_LEDS).
REQ-010 SHALL have port lut_commit  in  1  copies shadow tables to active tables.

Function
REQ-011 Driver d SHALL belong to group g = d / (NB_DRIVERS/NB_GROUPS).
REQ-012 For bit-plane b, LED l of driver d: out bits 3l+0 and 3l+1 of plane b SHALL equal in bits 3*RG[g][l]+0/+1 of plane b; out bit 3l+2 SHALL equal in bit 3*B[g][l]+2; plane offset = 3*NB_LEDS*b.
REQ-013 Frame transfer occurs on in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-014 Accepted frame SHALL appear on data_out with out_valid high the next cycle (latency 1), using active tables and bypass as sampled at acceptance.
REQ-015 data_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-016 out_valid SHALL clear after a consume cycle with no new acceptance; accept and consume in one cycle SHALL keep out_valid high with new data (full throughput).
REQ-017 lut_we SHALL write lut_val into shadow[lut_group][lut_sel][lut_led]; writes with lut_group >= NB_GROUPS or lut_val/lut_led >= NB_LEDS SHALL be ignored.
REQ-018 lut_commit SHALL copy all shadow tables to active on that clock edge, including a same-cycle write.
REQ-019 A frame accepted in the commit cycle SHALL use the pre-commit active tables; frames accepted later use new tables.
REQ-020 Tables are not checked for permutation validity; duplicate entries SHALL replicate the source LED.

Reset
REQ-021 On nrst low: out_valid = 0, data_out = 0, in_ready = 1 after deassertion.
REQ-022 On nrst low: shadow and active tables SHALL be identity (entry l = l) for every group and selector.
REQ-023 Reset mid-transfer SHALL discard the held frame; no partial output.

Configuration
REQ-024 With DRIVER_REMAP_LUT_WRITE_EN defined, REQ-017..REQ-019 apply.
REQ-025 Without DRIVER_REMAP_LUT_WRITE_EN, tables SHALL be constants fixed at reset values, lut_we/lut_commit ignored, no table registers inferred.

Verification
REQ-026 Reset, identity tables, bypass=0, random frame -> data_out equals data_in one cycle later, out_valid=1.
REQ-027 Write group0 RG[0]=6, B[0]=8, commit; frame with only plane0 bits 18,19,26 set on driver 0 -> out bits 0,1,2 set; drivers 5..14 unchanged.
REQ-028 out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, data_out stable; out_ready=1 -> next frame accepted, no loss or duplication over 100 back-to-back frames.
REQ-029 Commit in same cycle as acceptance -> that frame identity-mapped, next frame remapped.
REQ-030 lut_we with lut_group=3 (NB_GROUPS=3), commit -> all outputs unchanged versus identity.
REQ-031 Assert nrst with out_valid=1 and tables loaded -> out_valid=0, data_out=0, tables back to identity.
